// File: rtl/sequenciador_caminho.sv
// Walks the predecessor RAM from destination back to source, one read per hop,
// streaming every visited node out on a valid/ready interface (source is the last beat).
module sequenciador_caminho #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_HOPS   = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] top_fonte_in,
    input  logic [ADDR_WIDTH-1:0] top_destino_in,
    output logic                  ram_read_en_out,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_out,
    input  logic [ADDR_WIDTH-1:0] ram_read_data_in,
    output logic                  caminho_valid_out,
    output logic [ADDR_WIDTH-1:0] caminho_data_out,
    output logic                  caminho_last_out,
    input  logic                  caminho_ready_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  erro_out,
    output logic [ADDR_WIDTH-1:0] hop_count_out
);

    // Stream handshake: a beat transfers on the rising edge where caminho_valid_out and
    // caminho_ready_in are both 1; while valid is high and ready low, data/last hold still.

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_READ,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LIM = (ADDR_WIDTH + 1)'(MAX_HOPS);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] hop_q, hop_d;
    logic                  erro_q, erro_d;

    logic                  is_last;
    logic [ADDR_WIDTH:0]   hop_next;
    logic                  hop_err;

    assign is_last  = (cur_q == fonte_q);
    assign hop_next = {1'b0, hop_q} + ONE_W;
    // Self-loop in the table or too many reads both abort the walk.
    assign hop_err  = (ram_read_data_in == cur_q) || (hop_next > MAX_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            fonte_q <= '0;
            addr_q  <= '0;
            hop_q   <= '0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            fonte_q <= fonte_d;
            addr_q  <= addr_d;
            hop_q   <= hop_d;
            erro_q  <= erro_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        fonte_d = fonte_q;
        addr_d  = addr_q;
        hop_d   = hop_q;
        erro_d  = erro_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    fonte_d = top_fonte_in;
                    cur_d   = top_destino_in;
                    hop_d   = '0;
                    erro_d  = 1'b0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (caminho_ready_in) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = cur_q;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cur_d = ram_read_data_in;
                // Saturate so an oversized MAX_HOPS cannot wrap the counter.
                hop_d = hop_next[ADDR_WIDTH] ? '1 : hop_next[ADDR_WIDTH-1:0];
                if (hop_err) begin
                    erro_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ram_read_en_out   = (state_q == ST_READ);
    assign ram_read_addr_out = addr_q;
    assign caminho_valid_out = (state_q == ST_EMIT);
    assign caminho_data_out  = cur_q;
    assign caminho_last_out  = (state_q == ST_EMIT) && is_last;
    assign busy_out          = (state_q != ST_IDLE);
    assign done_out          = (state_q == ST_DONE);
    assign erro_out          = erro_q;
    assign hop_count_out     = hop_q;

endmodule

// File: tb/tb_sequenciador_caminho.sv
// Directed bench for sequenciador_caminho: predecessor RAM model, beat/read/done monitor,
// expected-queue scoreboard and hand-computed timing per path.
module tb_sequenciador_caminho;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_in;
    logic [AW-1:0] top_fonte_in;
    logic [AW-1:0] top_destino_in;
    logic          ram_read_en_out;
    logic [AW-1:0] ram_read_addr_out;
    logic [AW-1:0] ram_read_data_in;
    logic          caminho_valid_out;
    logic [AW-1:0] caminho_data_out;
    logic          caminho_last_out;
    logic          caminho_ready_in;
    logic          busy_out;
    logic          done_out;
    logic          erro_out;
    logic [AW-1:0] hop_count_out;

    sequenciador_caminho #(.ADDR_WIDTH(AW), .MAX_HOPS(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_in          (start_in),
        .top_fonte_in      (top_fonte_in),
        .top_destino_in    (top_destino_in),
        .ram_read_en_out   (ram_read_en_out),
        .ram_read_addr_out (ram_read_addr_out),
        .ram_read_data_in  (ram_read_data_in),
        .caminho_valid_out (caminho_valid_out),
        .caminho_data_out  (caminho_data_out),
        .caminho_last_out  (caminho_last_out),
        .caminho_ready_in  (caminho_ready_in),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .erro_out          (erro_out),
        .hop_count_out     (hop_count_out)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // predecessor RAM: data valid the cycle after the read enable
    logic [AW-1:0] mem [0:1023];
    initial ram_read_data_in = '0;
    always @(posedge clk) if (ram_read_en_out) ram_read_data_in <= mem[ram_read_addr_out];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // scoreboard state
    logic [AW:0]   exp_q[$];
    logic [AW:0]   got_q[$];
    int            beat_t[$];
    logic [AW-1:0] rd_addr[$];
    int            rd_t[$];
    int            done_n;
    int            done_t;
    int            start_cyc = 0;
    logic          stall_p = 1'b0;
    logic [AW:0]   stall_v;

    // monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p && caminho_valid_out)
                check("stall_hold", {caminho_last_out, caminho_data_out}, stall_v);
            stall_p = caminho_valid_out && !caminho_ready_in;
            stall_v = {caminho_last_out, caminho_data_out};
            if (caminho_valid_out && caminho_ready_in) begin
                got_q.push_back({caminho_last_out, caminho_data_out});
                beat_t.push_back(cyc - start_cyc);
            end
            if (ram_read_en_out) begin
                rd_addr.push_back(ram_read_addr_out);
                rd_t.push_back(cyc - start_cyc);
            end
            if (done_out) begin
                done_n++;
                done_t = cyc - start_cyc;
            end
        end
    end

    // driver tasks
    task automatic clear_sb();
        got_q.delete();
        beat_t.delete();
        rd_addr.delete();
        rd_t.delete();
        exp_q.delete();
        done_n = 0;
        done_t = -1;
    endtask

    function automatic logic rdy(input int mode, input int r);
        if (mode == 1) return !(r >= 1 && r <= 6);
        return 1'b1;
    endfunction

    // mode 0: ready high; mode 1: ready low on cycles 1-6; mode 2: extra starts while busy
    task automatic run_path(input string tag, input logic [AW-1:0] f, input logic [AW-1:0] d,
                            input int mode);
        clear_sb();
        @(posedge clk); #1;
        top_fonte_in   = f;
        top_destino_in = d;
        start_in       = 1'b1;
        start_cyc      = cyc;
        caminho_ready_in = rdy(mode, 0);
        for (int r = 1; r < 60 && done_n == 0; r++) begin
            @(posedge clk); #1;
            start_in = (mode == 2) && (r == 2 || r == 5);
            if (start_in) begin
                top_fonte_in   = 10'd0;
                top_destino_in = 10'd1;
            end
            caminho_ready_in = rdy(mode, r);
        end
        check({tag, "_done_cnt"}, done_n, 1);
        @(posedge clk); #1;
        start_in = 1'b0;
        caminho_ready_in = 1'b1;
        @(negedge clk);
        check({tag, "_idle_busy"}, busy_out, 0);
        check({tag, "_idle_done"}, done_out, 0);
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_beats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_beat"}, got_q[i], exp_q[i]);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[7]  = 10'd5;  mem[5]  = 10'd3;
        mem[9]  = 10'd9;
        mem[10] = 10'd11; mem[11] = 10'd12; mem[12] = 10'd13; mem[13] = 10'd14;
        mem[20] = 10'd21; mem[21] = 10'd22; mem[22] = 10'd23;
        mem[30] = 10'd31; mem[31] = 10'd32; mem[32] = 10'd33;

        rst = 1'b1;
        start_in = 1'b0;
        top_fonte_in = '0;
        top_destino_in = '0;
        caminho_ready_in = 1'b1;
        clear_sb();
        repeat (2) @(negedge clk);
        check("rst_busy", busy_out, 0);
        check("rst_valid", caminho_valid_out, 0);
        check("rst_rden", ram_read_en_out, 0);
        check("rst_hop", hop_count_out, 0);
        check("rst_erro", erro_out, 0);
        check("rst_done", done_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic path 7 -> 5 -> 3
        run_path("basic", 10'd3, 10'd7, 0);
        exp_q.push_back({1'b0, 10'd7});
        exp_q.push_back({1'b0, 10'd5});
        exp_q.push_back({1'b1, 10'd3});
        check_beats("basic");
        check("basic_t0", beat_t[0], 1);
        check("basic_t1", beat_t[1], 4);
        check("basic_t2", beat_t[2], 7);
        check("basic_nrd", rd_addr.size(), 2);
        check("basic_rd0", rd_addr[0], 7);
        check("basic_rdt0", rd_t[0], 2);
        check("basic_rd1", rd_addr[1], 5);
        check("basic_rdt1", rd_t[1], 5);
        check("basic_done_t", done_t, 8);
        check("basic_hop", hop_count_out, 2);
        check("basic_erro", erro_out, 0);

        // backpressure on cycles 1-6
        run_path("bp", 10'd3, 10'd7, 1);
        exp_q.push_back({1'b0, 10'd7});
        exp_q.push_back({1'b0, 10'd5});
        exp_q.push_back({1'b1, 10'd3});
        check_beats("bp");
        check("bp_t0", beat_t[0], 7);
        check("bp_t2", beat_t[2], 13);
        check("bp_done_t", done_t, 14);
        check("bp_hop", hop_count_out, 2);

        // trivial path
        run_path("triv", 10'd4, 10'd4, 0);
        exp_q.push_back({1'b1, 10'd4});
        check_beats("triv");
        check("triv_nrd", rd_addr.size(), 0);
        check("triv_done_t", done_t, 2);
        check("triv_hop", hop_count_out, 0);

        // self-loop error
        run_path("loop", 10'd1, 10'd9, 0);
        exp_q.push_back({1'b0, 10'd9});
        check_beats("loop");
        check("loop_nrd", rd_addr.size(), 1);
        check("loop_done_t", done_t, 4);
        check("loop_erro", erro_out, 1);
        check("loop_hop", hop_count_out, 1);

        // next start clears the sticky error
        run_path("clr", 10'd4, 10'd4, 0);
        check("clr_erro", erro_out, 0);
        exp_q.push_back({1'b1, 10'd4});
        check_beats("clr");

        // hop limit exceeded on the 4th read
        run_path("hlim", 10'd14, 10'd10, 0);
        exp_q.push_back({1'b0, 10'd10});
        exp_q.push_back({1'b0, 10'd11});
        exp_q.push_back({1'b0, 10'd12});
        exp_q.push_back({1'b0, 10'd13});
        check_beats("hlim");
        check("hlim_nrd", rd_addr.size(), 4);
        check("hlim_done_t", done_t, 13);
        check("hlim_erro", erro_out, 1);
        check("hlim_hop", hop_count_out, 4);

        // exactly MAX_HOPS reads is still legal
        run_path("h3", 10'd23, 10'd20, 0);
        exp_q.push_back({1'b0, 10'd20});
        exp_q.push_back({1'b0, 10'd21});
        exp_q.push_back({1'b0, 10'd22});
        exp_q.push_back({1'b1, 10'd23});
        check_beats("h3");
        check("h3_done_t", done_t, 11);
        check("h3_erro", erro_out, 0);
        check("h3_hop", hop_count_out, 3);

        // start pulses while busy are ignored
        run_path("abuse", 10'd3, 10'd7, 2);
        exp_q.push_back({1'b0, 10'd7});
        exp_q.push_back({1'b0, 10'd5});
        exp_q.push_back({1'b1, 10'd3});
        check_beats("abuse");
        check("abuse_done_t", done_t, 8);
        check("abuse_hop", hop_count_out, 2);

        // reset during the second WAIT of path 30 -> 31 -> 32 -> 33
        clear_sb();
        @(posedge clk); #1;
        top_fonte_in   = 10'd33;
        top_destino_in = 10'd30;
        start_in       = 1'b1;
        start_cyc      = cyc;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", busy_out, 0);
        check("mid_valid", caminho_valid_out, 0);
        check("mid_last", caminho_last_out, 0);
        check("mid_data", caminho_data_out, 0);
        check("mid_rden", ram_read_en_out, 0);
        check("mid_addr", ram_read_addr_out, 0);
        check("mid_hop", hop_count_out, 0);
        check("mid_done", done_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_no_done", done_n, 0);
        check("mid_beats", got_q.size(), 2);
        check("mid_idle", busy_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
